// File: rtl/param_serial_rx_if.sv
// Receive handshake between param_serial_rx (master) and the router core (slave).
// RX_Data_Valid/RX_Data are held by the receiver until a cycle with RX_Ready high.
interface param_serial_rx_if #(
  parameter int PKT_W = 55
);
  logic             RX_Data_Valid;
  logic [PKT_W-1:0] RX_Data;
  logic             RX_Ready;

  modport master (output RX_Data_Valid, output RX_Data, input RX_Ready);
  modport slave  (input RX_Data_Valid, input RX_Data, output RX_Ready);
endinterface

// File: rtl/param_serial_rx.sv
// Framed single-wire serial receiver with input synchroniser, holding register, overrun/framing
// detection and saturating error counter. Define RX_PARITY_EN to add an even-parity bit and Parity_Err.
module param_serial_rx #(
  parameter int PKT_W       = 55,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 Clk_S,
  input  logic                 Rst_n,
  input  logic                 S_Data,
  param_serial_rx_if.master    rx,
  output logic                 Busy,
  output logic                 Frame_Err,
  output logic                 Overrun_Err,
`ifdef RX_PARITY_EN
  output logic                 Parity_Err,
`endif
  output logic [ERR_CNT_W-1:0] Err_Count
);

  localparam int CNT_W = $clog2(PKT_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PKT_W - 1);

`ifdef RX_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd3
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PKT_W-1:0]     shift_q, shift_d;
  logic [PKT_W-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 s;
  logic                 discard_s;

`ifdef RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;

  function automatic logic even_parity_ok(input logic [PKT_W-1:0] d, input logic p);
    return ~((^d) ^ p);
  endfunction

  assign discard_s = par_bad_q;
`else
  assign discard_s = 1'b0;
`endif

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s = S_Data;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Synchroniser chain; resets to all ones so the line reads idle.
      always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
          sync_q <= '1;
        end else begin
          sync_q <= (sync_q << 1) | SYNC_STAGES'(S_Data);
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Next-state, datapath and error-pulse logic for the frame FSM.
  always_comb begin
    logic err_any;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef RX_PARITY_EN
    parity_err_d = 1'b0;
    par_bad_d    = par_bad_q;
`endif
    if (valid_q && rx.RX_Ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!s) begin
          state_d = ST_DATA;
          cnt_d   = '0;
`ifdef RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        shift_d = {shift_q[PKT_W-2:0], s};
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
`ifdef RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        state_d = ST_STOP;
        if (!even_parity_ok(shift_q, s)) begin
          parity_err_d = 1'b1;
          par_bad_d    = 1'b1;
        end else begin
          par_bad_d = 1'b0;
        end
      end
`endif
      ST_STOP: begin
        // A low stop bit returns to IDLE without being taken as the next start bit.
        state_d = ST_IDLE;
        if (s) begin
          if (discard_s) begin
            data_d = data_q;
          end else if (!valid_q || rx.RX_Ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          if (discard_s) begin
            frame_err_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef RX_PARITY_EN
    err_any = frame_err_d | overrun_d | parity_err_d;
`else
    err_any = frame_err_d | overrun_d;
`endif
    if (err_any && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      err_cnt_q   <= '0;
`ifdef RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= (state_d != ST_IDLE);
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      err_cnt_q   <= err_cnt_d;
`ifdef RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx.RX_Data_Valid = valid_q;
  assign rx.RX_Data       = data_q;
  assign Busy             = busy_q;
  assign Frame_Err        = frame_err_q;
  assign Overrun_Err      = overrun_q;
  assign Err_Count        = err_cnt_q;
`ifdef RX_PARITY_EN
  assign Parity_Err       = parity_err_q;
`endif

endmodule

// File: tb/tb_param_serial_rx.sv
// Self-checking bench for param_serial_rx: frame-level reference model (scheduled frame outcomes
// and holding-register handshake rules) compared against observed loads, pulses and outputs.
module tb_param_serial_rx;

  localparam int PKT_W       = 55;
  localparam int SYNC_STAGES = 2;
  localparam int ERR_CNT_W   = 8;
  localparam int ERR_MAX     = 255;
  localparam logic [63:0] MASK = (64'd1 << PKT_W) - 64'd1;
`ifdef RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic                 Clk_S = 1'b0;
  logic                 Rst_n = 1'b1;
  logic                 S_Data = 1'b1;
  logic                 Busy;
  logic                 Frame_Err;
  logic                 Overrun_Err;
  logic                 Parity_Err;
  logic [ERR_CNT_W-1:0] Err_Count;

  param_serial_rx_if #(.PKT_W(PKT_W)) rx_if ();

  param_serial_rx #(
    .PKT_W      (PKT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .ERR_CNT_W  (ERR_CNT_W)
  ) dut (
    .Clk_S      (Clk_S),
    .Rst_n      (Rst_n),
    .S_Data     (S_Data),
    .rx         (rx_if),
    .Busy       (Busy),
    .Frame_Err  (Frame_Err),
    .Overrun_Err(Overrun_Err),
`ifdef RX_PARITY_EN
    .Parity_Err (Parity_Err),
`endif
    .Err_Count  (Err_Count)
  );

`ifndef RX_PARITY_EN
  assign Parity_Err = 1'b0;
`endif

  always #5 Clk_S = ~Clk_S;

  typedef struct {
    int          start_e;
    int          par_e;
    int          dec_e;
    logic [63:0] data;
    bit          good_stop;
    bit          par_ok;
  } frame_rec_t;

  frame_rec_t  recs[$];
  logic [63:0] exp_load_d[$];
  int          exp_load_e[$];
  logic [63:0] obs_load_d[$];
  int          obs_load_e[$];

  int          edge_n = 0;
  bit          rdy_base = 1'b0;
  int          rdy_pulse_edge = -1;
  bit          m_valid = 1'b0;
  logic [63:0] m_data = 64'd0;
  int          m_err = 0;
  bit          e_busy = 1'b0;
  int n_ferr_exp = 0, n_oerr_exp = 0, n_perr_exp = 0;
  int n_ferr_obs = 0, n_oerr_obs = 0, n_perr_obs = 0, n_valid_obs = 0;
  int checks = 0, errors = 0;

  // Frame-level model: applies scheduled frame outcomes and the Valid/Ready rules at one edge.
  task automatic model_edge(input bit r);
    bit          ld;
    logic [63:0] nd;
    bit ferr, oerr, perr;
    ld = 1'b0; nd = 64'd0; ferr = 1'b0; oerr = 1'b0; perr = 1'b0;
    foreach (recs[i]) begin
      if (PAR_BITS == 1 && recs[i].par_e == edge_n && !recs[i].par_ok) perr = 1'b1;
      if (recs[i].dec_e == edge_n) begin
        if (recs[i].good_stop && recs[i].par_ok) begin
          if (!m_valid || r) begin ld = 1'b1; nd = recs[i].data; end
          else oerr = 1'b1;
        end else if (!recs[i].good_stop && recs[i].par_ok) begin
          ferr = 1'b1;
        end
      end
    end
    if (ld) begin
      m_valid = 1'b1; m_data = nd;
      exp_load_d.push_back(nd); exp_load_e.push_back(edge_n);
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    n_ferr_exp += int'(ferr); n_oerr_exp += int'(oerr); n_perr_exp += int'(perr);
    if ((ferr || oerr || perr) && m_err < ERR_MAX) m_err++;
    while (recs.size() > 0 && recs[0].dec_e <= edge_n) void'(recs.pop_front());
    e_busy = 1'b0;
    foreach (recs[i]) if (recs[i].start_e <= edge_n && edge_n < recs[i].dec_e) e_busy = 1'b1;
  endtask

  // One line bit per clock; updates the model at the edge and records observations #1 later.
  task automatic tick(input logic b);
    logic r, pv;
    S_Data = b;
    r = ((edge_n + 1) == rdy_pulse_edge) ? 1'b1 : rdy_base;
    rx_if.RX_Ready = r;
    pv = rx_if.RX_Data_Valid;
    @(posedge Clk_S);
    edge_n++;
    if (Rst_n) model_edge(r);
    #1;
    if (Frame_Err)   n_ferr_obs++;
    if (Overrun_Err) n_oerr_obs++;
    if (Parity_Err)  n_perr_obs++;
    if (rx_if.RX_Data_Valid) n_valid_obs++;
    if (rx_if.RX_Data_Valid && (!pv || r)) begin
      obs_load_d.push_back(64'(rx_if.RX_Data));
      obs_load_e.push_back(edge_n);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  function automatic int dec_edge_of(input int start_drive_e);
    return start_drive_e + PKT_W + 1 + PAR_BITS + SYNC_STAGES;
  endfunction

  task automatic send_frame(input logic [63:0] data, input bit good_stop, input bit flip_par);
    frame_rec_t f;
    logic [63:0] d;
    int e0;
    d  = data & MASK;
    e0 = edge_n + 1;
    f.start_e   = e0 + SYNC_STAGES;
    f.par_e     = e0 + PKT_W + 1 + SYNC_STAGES;
    f.dec_e     = dec_edge_of(e0);
    f.data      = d;
    f.good_stop = good_stop;
    f.par_ok    = (PAR_BITS == 0) ? 1'b1 : !flip_par;
    recs.push_back(f);
    tick(1'b0);
    for (int i = PKT_W - 1; i >= 0; i--) tick(d[i]);
    if (PAR_BITS == 1) tick((^d) ^ flip_par);
    tick(good_stop);
  endtask

  task automatic clear_logs();
    exp_load_d.delete(); exp_load_e.delete(); obs_load_d.delete(); obs_load_e.delete();
    n_ferr_exp = 0; n_oerr_exp = 0; n_perr_exp = 0;
    n_ferr_obs = 0; n_oerr_obs = 0; n_perr_obs = 0; n_valid_obs = 0;
  endtask

  task automatic model_reset();
    recs.delete();
    m_valid = 1'b0; m_data = 64'd0; m_err = 0; e_busy = 1'b0;
  endtask

  task automatic test_reset();
    rx_if.RX_Ready = 1'b0;
    #2 Rst_n = 1'b0;
    model_reset();
    tick(1'b1); tick(1'b1); tick(1'b1);
    checks += 6;
    if (rx_if.RX_Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", rx_if.RX_Data_Valid); end
    if (rx_if.RX_Data !== '0) begin errors++; $display("FAIL reset_data: got %0h expected 0", rx_if.RX_Data); end
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", Busy); end
    if (Frame_Err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", Frame_Err); end
    if (Overrun_Err !== 1'b0) begin errors++; $display("FAIL reset_oerr: got %0b expected 0", Overrun_Err); end
    if (Err_Count !== '0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", Err_Count); end
    Rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_nack();
    int stop_e;
    clear_logs();
    rdy_base = 1'b1;
    stop_e = edge_n + 1 + PKT_W + 1 + PAR_BITS;
    send_frame(64'h3FFFFFFFFFFFFF, 1'b1, 1'b0);
    idle(5);
    checks += 3;
    if (obs_load_d.size() !== 1) begin
      errors++; $display("FAIL nack_loads: got %0d loads expected 1", obs_load_d.size());
    end else begin
      checks += 2;
      if (obs_load_d[0] !== 64'h3FFFFFFFFFFFFF) begin errors++; $display("FAIL nack_data: got %0h expected 3fffffffffffff", obs_load_d[0]); end
      if (obs_load_e[0] - stop_e !== SYNC_STAGES) begin errors++; $display("FAIL nack_latency: got %0d expected %0d", obs_load_e[0] - stop_e, SYNC_STAGES); end
    end
    if (n_valid_obs !== 1) begin errors++; $display("FAIL nack_valid_width: got %0d cycles expected 1", n_valid_obs); end
    if (Err_Count !== '0) begin errors++; $display("FAIL nack_errcnt: got %0d expected 0", Err_Count); end
  endtask

  task automatic test_overrun();
    clear_logs();
    rdy_base = 1'b0;
    send_frame(64'h15555555555555, 1'b1, 1'b0);
    send_frame(64'h2AAAAAAAAAAAAA, 1'b1, 1'b0);
    idle(5);
    checks += 5;
    if (rx_if.RX_Data !== PKT_W'(64'h15555555555555)) begin errors++; $display("FAIL ovr_data_held: got %0h expected 15555555555555", rx_if.RX_Data); end
    if (rx_if.RX_Data_Valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %0b expected 1", rx_if.RX_Data_Valid); end
    if (n_oerr_obs !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", n_oerr_obs); end
    if (Err_Count !== ERR_CNT_W'(m_err) || m_err != 1) begin errors++; $display("FAIL ovr_errcnt: got %0d expected 1", Err_Count); end
    if (obs_load_d.size() !== 1) begin errors++; $display("FAIL ovr_loads: got %0d expected 1", obs_load_d.size()); end
    rdy_base = 1'b1;
    tick(1'b1);
    checks++;
    if (rx_if.RX_Data_Valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %0b expected 0", rx_if.RX_Data_Valid); end
    idle(2);
  endtask

  task automatic test_consume_load();
    int b_start;
    clear_logs();
    rdy_base = 1'b0;
    send_frame(64'h0123456789ABCD, 1'b1, 1'b0);
    idle(4);
    b_start = edge_n + 1;
    rdy_pulse_edge = dec_edge_of(b_start);
    send_frame(64'h7EDCBA98765432, 1'b1, 1'b0);
    idle(5);
    rdy_pulse_edge = -1;
    checks += 4;
    if (rx_if.RX_Data_Valid !== 1'b1) begin errors++; $display("FAIL cl_valid: got %0b expected 1", rx_if.RX_Data_Valid); end
    if (rx_if.RX_Data !== PKT_W'(64'h7EDCBA98765432)) begin errors++; $display("FAIL cl_data: got %0h expected 7edcba98765432", rx_if.RX_Data); end
    if (n_oerr_obs !== 0) begin errors++; $display("FAIL cl_overrun: got %0d expected 0", n_oerr_obs); end
    if (obs_load_e.size() !== 2) begin
      errors++; $display("FAIL cl_loads: got %0d expected 2", obs_load_e.size());
    end else if (obs_load_e[1] !== rdy_pulse_edge_saved(b_start)) begin
      errors++; $display("FAIL cl_load_edge: got %0d expected %0d", obs_load_e[1], dec_edge_of(b_start));
    end
    rdy_base = 1'b1;
    idle(3);
  endtask

  function automatic int rdy_pulse_edge_saved(input int b_start);
    return dec_edge_of(b_start);
  endfunction

  task automatic test_frame_err();
    clear_logs();
    rdy_base = 1'b1;
    send_frame(64'h00FF00FF00FF00, 1'b0, 1'b0);
    idle(6);
    checks += 4;
    if (n_ferr_obs !== 1 || n_ferr_exp != 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", n_ferr_obs); end
    if (obs_load_d.size() !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d loads expected 0", obs_load_d.size()); end
    if (Busy !== e_busy || e_busy) begin errors++; $display("FAIL ferr_idle_busy: got %0b expected 0", Busy); end
    if (Err_Count !== ERR_CNT_W'(m_err)) begin errors++; $display("FAIL ferr_errcnt: got %0d expected %0d", Err_Count, m_err); end
    send_frame(64'h2468ACE13579BD, 1'b1, 1'b0);
    idle(5);
    checks++;
    if (obs_load_d.size() !== 1 || obs_load_d[0] !== 64'h2468ACE13579BD) begin
      errors++; $display("FAIL ferr_recover: got %0d loads expected 1 with 2468ace13579bd", obs_load_d.size());
    end
  endtask

  task automatic test_saturate();
    clear_logs();
    rdy_base = 1'b1;
    for (int i = 0; i < 300; i++) send_frame({$urandom(), $urandom()}, 1'b0, 1'b0);
    idle(5);
    checks += 3;
    if (Err_Count !== ERR_CNT_W'(ERR_MAX)) begin errors++; $display("FAIL sat_errcnt: got %0d expected %0d", Err_Count, ERR_MAX); end
    if (n_ferr_obs !== 300) begin errors++; $display("FAIL sat_pulses: got %0d expected 300", n_ferr_obs); end
    if (Err_Count !== ERR_CNT_W'(m_err)) begin errors++; $display("FAIL sat_model: got %0d expected %0d", Err_Count, m_err); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    clear_logs();
    rdy_base = 1'b1;
    d = {$urandom(), $urandom()} & MASK;
    tick(1'b0);
    for (int i = 0; i <= 20; i++) tick(d[PKT_W-1-i]);
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b expected 1", Busy); end
    Rst_n = 1'b0;
    model_reset();
    #1;
    checks += 4;
    if (Busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b expected 0", Busy); end
    if (Err_Count !== '0) begin errors++; $display("FAIL mid_rst_errcnt: got %0d expected 0", Err_Count); end
    if (rx_if.RX_Data_Valid !== 1'b0 || rx_if.RX_Data !== '0) begin errors++; $display("FAIL mid_rst_out: got %0b/%0h expected 0/0", rx_if.RX_Data_Valid, rx_if.RX_Data); end
    if ((Frame_Err | Overrun_Err | Parity_Err) !== 1'b0) begin errors++; $display("FAIL mid_rst_pulses: got %0b expected 0", Frame_Err | Overrun_Err | Parity_Err); end
    for (int i = 0; i < 3; i++) tick(d[i]);
    Rst_n = 1'b1;
    idle(2);
    d = {$urandom(), $urandom()} & MASK;
    send_frame(d, 1'b1, 1'b0);
    idle(5);
    checks++;
    if (obs_load_d.size() !== 1 || obs_load_d[0] !== d) begin
      errors++; $display("FAIL mid_next_frame: got %0d loads expected 1 with %0h", obs_load_d.size(), d);
    end
`ifdef RX_PARITY_EN
    send_frame({$urandom(), $urandom()}, 1'b1, 1'b1);
    idle(5);
    checks += 2;
    if (n_perr_obs !== 1) begin errors++; $display("FAIL par_pulse: got %0d expected 1", n_perr_obs); end
    if (obs_load_d.size() !== 1 || n_ferr_obs !== 0) begin errors++; $display("FAIL par_discard: got %0d loads expected 1", obs_load_d.size()); end
`endif
  endtask

  task automatic test_random();
    clear_logs();
    for (int f = 0; f < 30; f++) begin
      rdy_base = ($urandom_range(0, 2) != 0);
      send_frame({$urandom(), $urandom()}, ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0));
      idle($urandom_range(0, 3));
    end
    rdy_base = 1'b0;
    idle(6);
    checks += 6;
    if (obs_load_d.size() !== exp_load_d.size()) begin
      errors++; $display("FAIL rnd_load_count: got %0d expected %0d", obs_load_d.size(), exp_load_d.size());
    end else begin
      foreach (exp_load_d[i]) begin
        checks++;
        if (obs_load_d[i] !== exp_load_d[i] || obs_load_e[i] !== exp_load_e[i]) begin
          errors++; $display("FAIL rnd_load_%0d: got %0h@%0d expected %0h@%0d", i, obs_load_d[i], obs_load_e[i], exp_load_d[i], exp_load_e[i]);
        end
      end
    end
    if (n_ferr_obs !== n_ferr_exp) begin errors++; $display("FAIL rnd_ferr: got %0d expected %0d", n_ferr_obs, n_ferr_exp); end
    if (n_oerr_obs !== n_oerr_exp) begin errors++; $display("FAIL rnd_oerr: got %0d expected %0d", n_oerr_obs, n_oerr_exp); end
    if (n_perr_obs !== n_perr_exp) begin errors++; $display("FAIL rnd_perr: got %0d expected %0d", n_perr_obs, n_perr_exp); end
    if (Err_Count !== ERR_CNT_W'(m_err)) begin errors++; $display("FAIL rnd_errcnt: got %0d expected %0d", Err_Count, m_err); end
    if (rx_if.RX_Data_Valid !== m_valid || (m_valid && rx_if.RX_Data !== m_data[PKT_W-1:0])) begin
      errors++; $display("FAIL rnd_hold: got %0b/%0h expected %0b/%0h", rx_if.RX_Data_Valid, rx_if.RX_Data, m_valid, m_data);
    end
  endtask

  initial begin
    test_reset();
    test_nack();
    test_overrun();
    test_consume_load();
    test_frame_err();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
